// File: rtl/ex_mul_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the multiplier-decomposition scheduler.
// Codes are {int_or_fra, i[4:0]}, six per engine result.
package ex_mul_sched_pkg;

  localparam int X_W     = 15;
  localparam int CODE_W  = 6;
  localparam int N_CODES = 6;
  localparam int CODES_W = N_CODES * CODE_W;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_HOLD  = 4'b1000
  } state_e;

  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/ex_mul_sched_if.sv
// Requester, engine and consumer signals of the scheduler, bundled as one interface.
// The master modport is the scheduler's view; slave is the surrounding environment.
interface ex_mul_sched_if
  import ex_mul_sched_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*X_W-1:0]   req_x;
  logic [N_REQ-1:0]       req_ready;
  logic [X_W-1:0]         eng_x;
  logic                   eng_start;
  logic                   eng_done;
  logic [CODES_W-1:0]     eng_codes;
  logic                   res_valid;
  logic                   res_ready;
  logic [ID_W-1:0]        res_id;
  logic [CODES_W-1:0]     res_codes;
  logic                   res_timeout;
  logic                   busy;

  modport master (
    input  req_valid, req_x, eng_done, eng_codes, res_ready,
    output req_ready, eng_x, eng_start, res_valid, res_id, res_codes, res_timeout, busy
  );

  modport slave (
    output req_valid, req_x, eng_done, eng_codes, res_ready,
    input  req_ready, eng_x, eng_start, res_valid, res_id, res_codes, res_timeout, busy
  );

endinterface

// File: rtl/ex_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or above ptr, wrapping.
// Produces a one-hot grant and its encoded index.
module ex_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] rot_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   seen;
  logic [N_REQ-1:0]   first;
  logic [2*N_REQ-1:0] first_dbl;
  logic [2*N_REQ-1:0] gnt_dbl;

  // Doubling the vector turns the wrap-around into a plain shift; both halves
  // carry the same bit at any index they share, so OR-ing them is exact.
  assign req_dbl   = {req, req};
  assign rot_dbl   = req_dbl >> ptr;
  assign rot       = rot_dbl[N_REQ-1:0] | rot_dbl[2*N_REQ-1:N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_prio
      if (gi == 0) begin : g_first
        assign seen[gi] = 1'b0;
      end else begin : g_rest
        assign seen[gi] = seen[gi-1] | rot[gi-1];
      end
      assign first[gi] = rot[gi] & ~seen[gi];
    end
  endgenerate

  assign first_dbl = {first, first};
  assign gnt_dbl   = first_dbl << ptr;
  assign gnt       = gnt_dbl[2*N_REQ-1:N_REQ] | gnt_dbl[N_REQ-1:0];
  assign gnt_any   = |req;

  always_comb begin
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) gnt_id = gnt_id | ID_W'(k);
    end
  end

endmodule

// File: rtl/ex_mul_sched.sv
// Round-robin scheduler sharing one multiplier-decomposition engine among N_REQ requesters,
// with a watchdog that closes engine runs that retire without a done pulse.
module ex_mul_sched
  import ex_mul_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_mul_sched_if.master bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = $clog2(TIMEOUT);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [X_W-1:0]     eng_x_q, eng_x_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               eng_start_q, eng_start_d;
  logic               res_valid_q, res_valid_d;
  logic               res_timeout_q, res_timeout_d;
  logic               busy_q, busy_d;
  logic [CODES_W-1:0] res_codes_q, res_codes_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [X_W-1:0]     gnt_x;

  ex_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  always_comb begin
    gnt_x = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) gnt_x = bus.req_x[k*X_W +: X_W];
    end
  end

  // eng_start and req_ready are raised on the transition into ISSUE so that,
  // being registered, they are high exactly during the ISSUE cycle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    eng_x_d       = eng_x_q;
    req_ready_d   = '0;
    eng_start_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_codes_d   = res_codes_q;
    res_timeout_d = res_timeout_q;
    wd_d          = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d     = ST_ISSUE;
          eng_x_d     = gnt_x;
          id_d        = gnt_id;
          req_ready_d = gnt;
          eng_start_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.eng_done) begin
          res_codes_d   = bus.eng_codes;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_codes_d   = bus.eng_codes;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = ID_W'(rr_next(int'(id_q), N_REQ));
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      eng_x_q       <= '0;
      req_ready_q   <= '0;
      eng_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_codes_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      eng_x_q       <= eng_x_d;
      req_ready_q   <= req_ready_d;
      eng_start_q   <= eng_start_d;
      res_valid_q   <= res_valid_d;
      res_codes_q   <= res_codes_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      wd_q          <= wd_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.eng_x       = eng_x_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_id      = id_q;
  assign bus.res_codes   = res_codes_q;
  assign bus.res_timeout = res_timeout_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ex_mul_sched.sv
// Directed bench for ex_mul_sched with a behavioural engine: fixed run length,
// codes {n odd, (x >> 2n)[4:0]}, and early retirement (no done) for x == 0.
module tb_ex_mul_sched;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 32;
  localparam int ENG_RUN = 6;

  logic clk;
  logic rst_n;
  logic [N_REQ-1:0] req_valid_r;
  logic [14:0]      req_x_arr [N_REQ];
  logic [N_REQ-1:0] reload;
  logic             res_ready_r;
  logic             spur;

  ex_mul_sched_if #(.N_REQ(N_REQ)) bus ();

  ex_mul_sched #(
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] exp_codes(input logic [14:0] x);
    logic [35:0] r;
    logic [14:0] s;
    r = '0;
    for (int n = 0; n < 6; n++) begin
      s = x >> (2 * n);
      r[n*6 +: 6] = {(n % 2 == 1), s[4:0]};
    end
    return r;
  endfunction

  // Engine model
  logic        eng_run;
  logic [4:0]  eng_cnt;
  logic        eng_zero;
  logic [14:0] eng_xl;
  logic        done_m;
  logic [35:0] codes_m;
  int          start_overlap = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_run  <= 1'b0;
      eng_cnt  <= '0;
      eng_zero <= 1'b0;
      eng_xl   <= '0;
      done_m   <= 1'b0;
      codes_m  <= '0;
    end else begin
      done_m <= 1'b0;
      if (bus.eng_start) begin
        if (eng_run) start_overlap <= start_overlap + 1;
        eng_run  <= 1'b1;
        eng_xl   <= bus.eng_x;
        eng_zero <= (bus.eng_x == 15'h0000);
        eng_cnt  <= (bus.eng_x == 15'h0000) ? 5'd10 : 5'(ENG_RUN);
      end else if (eng_run) begin
        eng_cnt <= eng_cnt - 5'd1;
        if (eng_cnt == 5'd1) begin
          eng_run <= 1'b0;
          if (!eng_zero) begin
            done_m  <= 1'b1;
            codes_m <= exp_codes(eng_xl);
          end
        end
      end
    end
  end

  assign bus.eng_done  = done_m | spur;
  assign bus.eng_codes = spur ? {36{1'b1}} : codes_m;
  assign bus.req_valid = req_valid_r;
  assign bus.req_x     = {req_x_arr[3], req_x_arr[2], req_x_arr[1], req_x_arr[0]};
  assign bus.res_ready = res_ready_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_start  = 0;
  int n_res    = 0;
  int last_start_cyc = 0;
  int rv_rise_cyc    = 0;
  logic res_valid_prev = 1'b0;
  int   gnt_q [$];
  int   sb_id [$];
  logic [14:0] sb_x [$];
  logic [35:0] last_codes = '0;
  logic [35:0] last_res_codes = '0;
  int          last_res_id = 0;
  logic        last_res_to = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, update requesters just after the rising edge.
  task automatic tick();
    logic [N_REQ-1:0] rr;
    int          id;
    logic [14:0] x;
    logic        exp_to;
    logic [35:0] exp_c;
    @(negedge clk);
    cyc++;
    rr = bus.req_ready;
    if (bus.eng_start) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (bus.res_valid && !res_valid_prev) rv_rise_cyc = cyc;
    res_valid_prev = bus.res_valid;
    for (int k = 0; k < N_REQ; k++) begin
      if (rr[k]) begin
        gnt_q.push_back(k);
        sb_id.push_back(k);
        sb_x.push_back(req_x_arr[k]);
      end
    end
    if (bus.res_valid && res_ready_r) begin
      chk_eq("sb_pending", sb_id.size() != 0, 1);
      if (sb_id.size() != 0) begin
        id     = sb_id.pop_front();
        x      = sb_x.pop_front();
        exp_to = (x == 15'h0000);
        exp_c  = exp_to ? last_codes : exp_codes(x);
        chk_eq("res_id", bus.res_id, id);
        chk_eq("res_timeout", bus.res_timeout, exp_to);
        chk_eq("res_codes", bus.res_codes, exp_c);
        if (!exp_to) last_codes = exp_c;
        last_res_codes = bus.res_codes;
        last_res_id    = int'(bus.res_id);
        last_res_to    = bus.res_timeout;
        n_res++;
        $display("txn id=%0d x=%h codes=%h timeout=%0d cyc=%0d",
                 bus.res_id, x, bus.res_codes, bus.res_timeout, cyc);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N_REQ; k++) begin
      if (rr[k]) begin
        if (reload[k]) req_x_arr[k] = req_x_arr[k] + 15'h0123;
        else           req_valid_r[k] = 1'b0;
      end
    end
  endtask

  task automatic run_until_res(input int n, input int budget, input string tag);
    int target;
    int c;
    target = n_res + n;
    c = 0;
    while (n_res < target && c < budget) begin
      tick();
      c++;
    end
    chk_eq(tag, n_res >= target, 1);
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (bus.busy && c < 100) begin
      tick();
      c++;
    end
    chk_eq(tag, bus.busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_id.delete();
    sb_x.delete();
    gnt_q.delete();
    last_codes = '0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk_eq({tag, "_busy"},      bus.busy, 0);
    chk_eq({tag, "_res_valid"}, bus.res_valid, 0);
    chk_eq({tag, "_req_ready"}, bus.req_ready, 0);
    chk_eq({tag, "_eng_start"}, bus.eng_start, 0);
    chk_eq({tag, "_res_id"},    bus.res_id, 0);
    chk_eq({tag, "_res_codes"}, bus.res_codes, 0);
    chk_eq({tag, "_res_to"},    bus.res_timeout, 0);
    chk_eq({tag, "_eng_x"},     bus.eng_x, 0);
  endtask

  initial begin
    int c;
    int gsz;
    int s0;
    int bad;
    rst_n       = 1'b0;
    req_valid_r = '0;
    reload      = '0;
    res_ready_r = 1'b1;
    spur        = 1'b0;
    for (int k = 0; k < N_REQ; k++) req_x_arr[k] = '0;
    tick();
    tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single request from requester 0, x = 1.0
    s0 = n_start;
    req_x_arr[0] = 15'h0800;
    req_valid_r[0] = 1'b1;
    run_until_res(1, 100, "t1_done");
    chk_eq("t1_grants", gnt_q.size(), 1);
    chk_eq("t1_grant_id", gnt_q[0], 0);
    chk_eq("t1_starts", n_start - s0, 1);
    chk_eq("t1_latency", rv_rise_cyc - last_start_cyc, ENG_RUN + 2);
    chk_eq("t1_codes", last_res_codes, 36'h888800800);
    chk_eq("t1_id", last_res_id, 0);
    chk_eq("t1_to", last_res_to, 0);
    wait_idle("t1_idle");

    // 2: all four requesters continuously valid
    do_reset();
    req_x_arr[0] = 15'h0100;
    req_x_arr[1] = 15'h0200;
    req_x_arr[2] = 15'h0300;
    req_x_arr[3] = 15'h0400;
    reload = 4'hF;
    req_valid_r = 4'hF;
    s0 = n_res;
    c = 0;
    while (gnt_q.size() < 5 && c < 200) begin
      tick();
      c++;
    end
    req_valid_r = '0;
    reload = '0;
    chk_eq("t2_five_grants", gnt_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk_eq("t2_order", gnt_q[i], i % 4);
    run_until_res(5 - (n_res - s0), 100, "t2_drain");
    wait_idle("t2_idle");

    // 3: early retirement, then a normal job from the same requester
    req_x_arr[1] = 15'h0000;
    req_valid_r[1] = 1'b1;
    run_until_res(1, 100, "t3_done");
    chk_eq("t3_wd_latency", rv_rise_cyc - last_start_cyc, TIMEOUT + 1);
    chk_eq("t3_timeout", last_res_to, 1);
    chk_eq("t3_id", last_res_id, 1);
    req_x_arr[1] = 15'h1234;
    req_valid_r[1] = 1'b1;
    run_until_res(1, 100, "t3_next_done");
    chk_eq("t3_next_to", last_res_to, 0);
    chk_eq("t3_next_codes", last_res_codes, exp_codes(15'h1234));
    wait_idle("t3_idle");

    // 5a: spurious done while idle
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk_eq("t5_idle_busy", bus.busy, 0);
    chk_eq("t5_idle_rv", bus.res_valid, 0);
    chk_eq("t5_idle_start", bus.eng_start, 0);
    chk_eq("t5_idle_codes", bus.res_codes, exp_codes(15'h1234));
    chk_eq("t5_idle_id", bus.res_id, 1);

    // 5b + 4: spurious done in HOLD and back-pressure with requester 2 pending
    res_ready_r = 1'b0;
    req_x_arr[0] = 15'h2468;
    req_valid_r[0] = 1'b1;
    c = 0;
    while (!bus.res_valid && c < 100) begin
      tick();
      c++;
    end
    chk_eq("t5_hold_reached", bus.res_valid, 1);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    req_x_arr[2] = 15'h0555;
    req_valid_r[2] = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bus.res_valid) bad++;
      if (bus.res_codes !== exp_codes(15'h2468)) bad++;
      if (bus.res_id !== 2'd0 || bus.res_timeout !== 1'b0) bad++;
      if (bus.req_ready[2] || bus.eng_start) bad++;
    end
    chk_eq("t4_hold_stable", bad, 0);
    chk_eq("t4_hold_codes", bus.res_codes, exp_codes(15'h2468));
    gsz = gnt_q.size();
    res_ready_r = 1'b1;
    run_until_res(2, 100, "t4_drain");
    chk_eq("t4_next_grant", gnt_q[gsz], 2);
    wait_idle("t4_idle");

    // 6: reset mid-WAIT, then requesters 1 and 3 compete from rr_ptr 0
    req_x_arr[3] = 15'h0707;
    req_valid_r[3] = 1'b1;
    s0 = n_start;
    c = 0;
    while (n_start == s0 && c < 20) begin
      tick();
      c++;
    end
    chk_eq("t6_started", n_start - s0, 1);
    tick();
    tick();
    do_reset();
    chk_zero_outputs("t6_reset");
    req_x_arr[1] = 15'h0321;
    req_x_arr[3] = 15'h0654;
    req_valid_r[1] = 1'b1;
    req_valid_r[3] = 1'b1;
    run_until_res(2, 200, "t6_done");
    chk_eq("t6_first_grant", gnt_q[0], 1);
    chk_eq("t6_second_grant", gnt_q[1], 3);
    wait_idle("t6_idle");

    chk_eq("no_start_overlap", start_overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d limit=200000ns", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
